// File: rtl/hb_best_match_seq_pkg.sv
// ============================================================================
// Module   : hb_best_match_seq_pkg
// Brief    : Shared state encoding and score constants for the best-match
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hb_best_match_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         SCORE_W   = 5;
   localparam logic [4:0] MAX_SCORE = 5'd16;

endpackage

`default_nettype wire

// File: rtl/hammingbenzer16bit.sv
// ============================================================================
// Module   : hammingbenzer16bit
// Brief    : Combinational 16-bit similarity: count of equal bit positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hammingbenzer16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [4:0]  hb
);

   always_comb begin
      hb = '0;
      for (int i = 0; i < 16; i++) begin
         hb = hb + {4'b0000, a[i] ~^ b[i]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/hb_best_match_seq.sv
// ============================================================================
// Module   : hb_best_match_seq
// Brief    : Scans a small word table one entry per clock through a shared
//            similarity unit and reports the best-matching index and score.
//            Optional macro HB_EXACT_EARLY_EXIT_EN stops at the first exact hit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hb_best_match_seq
   import hb_best_match_seq_pkg::*;
#(
   parameter int N_WORDS = 8,
   parameter int IDX_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_addr,
   input  logic [15:0]        wr_data,
   input  logic               start,
   input  logic [15:0]        query,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   best_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic               exact
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_WORDS - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [15:0]          r_table [N_WORDS];
   logic [15:0]          r_query;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     r_best_idx;
   logic [SCORE_W-1:0]   r_best_score;
   logic [SCORE_W-1:0]   w_score;
   logic                 w_take;
   logic                 w_exit;
   logic                 w_accept;
   logic                 w_wr_ok;

   hammingbenzer16bit u_hb (
      .a  (r_query),
      .b  (r_table[r_idx]),
      .hb (w_score)
   );

   // Strict compare keeps the lowest index on ties.
   assign w_take   = (r_idx == '0) || (w_score > r_best_score);
   assign w_accept = (r_state == IDLE) && start;
   assign w_wr_ok  = wr_en && (r_state != SCAN) && ({24'd0, wr_addr} < 32'(N_WORDS));

`ifdef HB_EXACT_EARLY_EXIT_EN
   assign w_exit = (r_idx == c_last_idx) || (w_score == MAX_SCORE);
`else
   assign w_exit = (r_idx == c_last_idx);
`endif

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = SCAN;
         end
         SCAN: begin
            busy = 1'b1;
            if (w_exit) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_query      <= '0;
         r_idx        <= '0;
         r_best_idx   <= '0;
         r_best_score <= '0;
         for (int i = 0; i < N_WORDS; i++) begin
            r_table[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_ok) begin
            r_table[wr_addr] <= wr_data;
         end
         if (w_accept) begin
            r_query      <= query;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
         end
         if (r_state == SCAN) begin
            r_idx <= r_idx + 1'b1;
            if (w_take) begin
               r_best_idx   <= r_idx;
               r_best_score <= w_score;
            end
         end
      end
   end

   assign best_idx   = r_best_idx;
   assign best_score = r_best_score;
   assign exact      = (r_best_score == MAX_SCORE);

endmodule

`default_nettype wire

// File: tb/tb_hb_best_match_seq.sv
// ============================================================================
// Module   : tb_hb_best_match_seq
// Brief    : Directed and randomized self-checking bench for hb_best_match_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hb_best_match_seq;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          start;
   logic [15:0]   query;
   logic          busy;
   logic          done;
   logic [IW-1:0] best_idx;
   logic [4:0]    best_score;
   logic          exact;

   int            errors = 0;
   int            checks = 0;
   logic [15:0]   m_table [N];

   hb_best_match_seq #(.N_WORDS(N), .IDX_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .query      (query),
      .busy       (busy),
      .done       (done),
      .best_idx   (best_idx),
      .best_score (best_score),
      .exact      (exact)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sim(input logic [15:0] a, input logic [15:0] b);
      return $countones(~(a ^ b));
   endfunction

   // Reference: best is the lowest index holding the maximum similarity.
   function automatic void model(input logic [15:0] q, output int idx, output int score,
                                 output int lat);
      idx   = 0;
      score = -1;
      lat   = N + 1;
      for (int i = 0; i < N; i++) begin
         if (sim(q, m_table[i]) > score) begin
            score = sim(q, m_table[i]);
            idx   = i;
         end
      end
`ifdef HB_EXACT_EARLY_EXIT_EN
      for (int i = N - 1; i >= 0; i--) begin
         if (sim(q, m_table[i]) == 16) lat = i + 2;
      end
`endif
   endfunction

   // Called at a falling edge; returns at a falling edge.
   task automatic wr(input int a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = IW'(a);
      wr_data = d;
      m_table[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic scan(input string tag, input logic [15:0] q, input bit inject,
                       input bit wr_same, input int ws_addr, input logic [15:0] ws_data);
      int idx, score, lat;
      int k_done = -1;
      int pulses = 0;
      start = 1'b1;
      query = q;
      if (wr_same) begin
         wr_en   = 1'b1;
         wr_addr = IW'(ws_addr);
         wr_data = ws_data;
         m_table[ws_addr] = ws_data;
      end
      model(q, idx, score, lat);
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      query = 16'($urandom);
      for (int k = 1; k <= N + 4; k++) begin
         if (done) begin
            pulses++;
            if (k_done < 0) k_done = k;
         end
         if (k == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
         if (inject && k == 3) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 3'd7;
            wr_data = 16'h1234;
         end
         if (inject && k == 4) begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_latency"}, 32'(k_done), 32'(lat));
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_idx"}, 32'(best_idx), 32'(idx));
      check({tag, "_score"}, 32'(best_score), 32'(score));
      check({tag, "_exact"}, 32'(exact), 32'(score == 16));
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dcount;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; query = '0;
      for (int i = 0; i < N; i++) m_table[i] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_idx", 32'(best_idx), 32'd0);
      check("rst_score", 32'(best_score), 32'd0);
      check("rst_exact", 32'(exact), 32'd0);

      scan("default", 16'h0000, 1'b0, 1'b0, 0, '0);

      wr(5, 16'hFFF0);
      scan("single", 16'hFFFF, 1'b0, 1'b0, 0, '0);

      for (int i = 0; i < N; i++) wr(i, (i == 2 || i == 6) ? 16'h00FF : 16'hFF00);
      scan("tie", 16'h00FF, 1'b0, 1'b0, 0, '0);

      scan("inject", 16'h0F0F, 1'b1, 1'b0, 0, '0);
      scan("after_inject", 16'h1234, 1'b0, 1'b0, 0, '0);
      check("t7_dropped", 32'(best_idx == 3'd7 && best_score == 5'd16), 32'd0);

      // Reset lands on the edge at t+4.
      start = 1'b1;
      query = 16'h5A5A;
      @(negedge clk);
      start = 1'b0;
      dcount = 0;
      for (int k = 1; k < 4; k++) begin
         if (done) dcount++;
         if (k == 3) rst = 1'b1;
         @(negedge clk);
      end
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_score", 32'(best_score), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < N; i++) m_table[i] = '0;
      for (int k = 0; k < 12; k++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      check("midrst_nodone", 32'(dcount), 32'd0);
      scan("post_rst", 16'($urandom), 1'b0, 1'b0, 0, '0);

      wr(3, 16'hA5A5);
      scan("early", 16'hA5A5, 1'b0, 1'b0, 0, '0);

      scan("wr_start", 16'hC3C3, 1'b0, 1'b1, 4, 16'hC3C3);

      for (int r = 0; r < 6; r++) begin
         logic [15:0] q;
         q = 16'($urandom);
         for (int i = 0; i < N; i++) wr(i, 16'($urandom));
         if (r[0]) wr(int'($urandom_range(0, N - 1)), q);
         if (r == 4) begin
            wr(1, q ^ 16'h0003);
            wr(5, q ^ 16'h0003);
         end
         scan($sformatf("rand%0d", r), q, 1'b0, 1'b0, 0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hb_best_match_seq.md
Name: hb_best_match_seq

Overview:
- Sequencer that time-shares one combinational 16-bit Hamming-similarity unit across a small on-chip table of stored words.
- On a start request, it scans the table one entry per clock and compares each entry against a query word.
- Reports the index and score of the most similar entry. Score is the count of equal bit positions, 0..16.
- Sits between a host or control FSM and the similarity datapath. It is the only driver of that datapath's A/B inputs.

Parameters:
- N_WORDS, 8, number of stored 16-bit entries; legal range 2..256.
- IDX_W, 3, index width; must equal clog2(N_WORDS).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  table write strobe.
- wr_addr  input  IDX_W  table write address.
- wr_data  input  16  table write data.
- start  input  1  scan request; sampled high for one cycle.
- query  input  16  query word; captured on the cycle start is accepted.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- best_idx  output  IDX_W  index of the best-matching entry.
- best_score  output  5  similarity of that entry, 0..16.
- exact  output  1  high when best_score == 16.

Behaviour:
- Reset
  - Synchronous, active-high on rst; applies to the next rising clk edge.
  - Clears: state to IDLE, busy=0, done=0, best_idx=0, best_score=0, exact=0, all table entries to 0x0000, scan index to 0.
  - Reset mid-scan aborts the scan. No done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE
  - wr_en=1 writes wr_data to table[wr_addr] at the clock edge.
  - start=1 latches query and clears idx, best_idx and best_score. Next state is SCAN.
  - If wr_en and start are high in the same cycle, both take effect. The scan sees the newly written entry.
- SCAN
  - busy=1.
  - The datapath is driven with A=query_latched, B=table[idx]; score = popcount(~(A^B)), 5 bits unsigned.
  - Update rule: take the entry if idx==0 or score > best_score (strict). Ties resolve to the lowest index.
  - idx increments each cycle. After idx==N_WORDS-1 is evaluated, next state is DONE.
  - start is ignored. wr_en is ignored (the write is dropped), so the table stays stable during a scan.
- DONE
  - One cycle. done=1, busy=0. Next state is IDLE.
  - start is ignored in DONE; the host re-issues start in IDLE.
  - wr_en is honoured in DONE.
- Latency: start accepted at cycle t → SCAN at t+1..t+N_WORDS → done at t+N_WORDS+1.
- Result hold: best_idx, best_score and exact hold their values until the next accepted start. At that start they clear to 0 during the scan.
- exact is combinational from the best_score register.

Optional Feature:
- Macro: HB_EXACT_EARLY_EXIT_EN.
- Defined: in SCAN, a score of 16 is recorded and the FSM goes directly to DONE on the next edge. Latency becomes idx_of_first_exact+2 cycles after start. The first exact match wins.
- Undefined: the full table is always scanned. Latency is fixed at N_WORDS+1.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, SCAN=2'd1, DONE=2'd2
  - SCORE_W=5
  - MAX_SCORE=16
- Sub-module: the existing hammingbenzer16bit similarity unit, instantiated once (A, B → HB[4:0]). No new sub-module is required.

Test Plan:
- Reset default: table all 0x0000, query 0x0000, start → done at cycle t+9; best_idx=0, best_score=16, exact=1.
- Single best: table[5]=0xFFF0, others 0x0000, query 0xFFFF → best_idx=5, best_score=12, exact=0.
- Tie-break: table[2]=table[6]=0x00FF, others 0xFF00, query 0x00FF → best_idx=2, best_score=16.
- Ignored inputs: during SCAN pulse start and write table[7]=0x1234 → no restart, done exactly once at t+9, table[7] unchanged. A following scan with query 0x1234 does not return idx 7 at score 16.
- Reset mid-scan: assert rst at t+4 → busy=0, best_score=0, no done pulse. A new start runs a full scan correctly.
- Early exit (macro defined): table[3]=0xA5A5, query 0xA5A5 → done at t+5, best_idx=3, exact=1. With the macro undefined, done at t+9 with the same result.
